cim_acc_buffer: RTL
===================

// Module: cim_acc_buffer
// PURPOSE
// On-chip 512-bit x DEPTH accumulation buffer serving the CIM adder as its memory side.
// Each accepted PE tile address triggers a read-modify-write: the buffer word is read, presented to CIM, and CIM's sum is written back.
// Also provides a bulk clear (zero fill) and a sequential drain port to stream final accumulated tiles out.
// PARAMETERS
// DEPTH  256  number of 512-bit words (one 6x6x12b tile per word, bits [431:0] used)
// AW     8    address width, log2(DEPTH)
// DW     512  word width
// PORTS
// clk_i          in   1   clock, all logic on rising edge
// rst_i          in   1   synchronous, active-high reset
// pe_valid_i     in   1   PE tile address valid (PE tile itself goes straight to CIM)
// pe_addr_i      in   AW  buffer address of incoming PE tile
// pe_ready_o     out  1   buffer accepts pe_addr_i this cycle
// mem_data_o     out  DW  buffer word to CIM memory_data_i
// mem_addr_o     out  AW  address of mem_data_o, to CIM memory_addr_i
// mem_valid_o    out  1   mem_data_o valid, to CIM memory_valid_i
// cim_result_i   in   DW  CIM result_o
// cim_addr_i     in   AW  CIM result_addr_o
// cim_valid_i    in   1   CIM result_valid_o
// clear_i        in   1   one-cycle pulse: zero entire buffer
// drain_start_i  in   1   one-cycle pulse: stream words 0..DEPTH-1 out
// drain_data_o   out  DW  drained word
// drain_addr_o   out  AW  address of drained word
// drain_valid_o  out  1   drain word valid
// drain_ready_i  in   1   drain consumer ready
// busy_o         out  1   high in CLEAR/DRAIN or with a command pending
// err_o          out  1   sticky: CIM result missing or address mismatch
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, pending flags cleared. Memory array NOT reset; software issues clear_i.
// - States: IDLE, CLEAR, DRAIN. Decoder-level: pe_ready_o = (state==IDLE) && !clr_pend && !drn_pend.
// - Accumulate pipeline: handshake pe_valid_i&&pe_ready_o at cycle t -> read issued; at t+1 mem_valid_o=1,
//   mem_addr_o=addr, mem_data_o=word. CIM is combinational: at t+1 expect cim_valid_i=1, cim_addr_i=addr;
//   cim_result_i written to addr at end of t+1. Throughput 1 tile/cycle, latency 1 cycle.
// - Write-to-read bypass: if the write at cycle t+1 targets the address being read for the tile accepted at t+1,
//   mem_data_o at t+2 is the just-written cim_result_i (back-to-back same-address tiles accumulate correctly).
// - At t+1 if !cim_valid_i or cim_addr_i!=addr: no write, err_o set (clears only on rst_i).
// - Commands: clear_i/drain_start_i pulses set clr_pend/drn_pend (only while IDLE; ignored in CLEAR/DRAIN).
//   Pending command leaves IDLE once no tile is in flight (mem_valid_o==0). Both pending: CLEAR first, then DRAIN.
//   A pulse in the same cycle as a pe handshake: the tile is accepted and completes, command follows.
// - CLEAR: counter 0..DEPTH-1, writes zero one word/cycle; DEPTH cycles, then IDLE; clr_pend cleared on entry.
// - DRAIN: sequential registered reads addr 0..DEPTH-1; drain_valid_o/drain_data_o/drain_addr_o held stable
//   while drain_valid_o&&!drain_ready_i; next word presented cycle after handshake (ready held high -> 1 word/cycle,
//   first word 1 cycle after entering DRAIN). After handshake of addr DEPTH-1 -> IDLE. Drain is non-destructive.
// - Counter wrap: CLEAR/DRAIN counters stop at DEPTH-1; no wrap to 0 in-state.
// - rst_i mid-CLEAR/DRAIN/accumulate: aborts immediately, outputs to reset values, in-flight write dropped.
// - mem_valid_o, drain_valid_o are 0 whenever their state is not active; data outputs 0 when not valid.
// TESTING
// 1. rst, clear_i, wait DEPTH+2 cycles; drain all with ready=1 -> 256 words all 0, addr 0..255, busy_o low after.
// 2. After clear, 3 tiles to addr 5 on consecutive cycles, each elem +1 -> drain word 5 elems = 3 (bypass), others 0.
// 3. Tiles to addr 7 then 9 alternating, elem values -2 and +5 -> elem 12-bit wrap correct, no err_o.
// 4. Drain with drain_ready_i toggling 1,0,0,1 -> data/addr stable during stall, no word skipped or duplicated.
// 5. clear_i and drain_start_i same cycle as pe handshake -> tile completes, CLEAR then DRAIN, pe_ready_o=0 until IDLE.
// 6. Force cim_valid_i=0 at t+1 -> no write, err_o=1 sticky; rst_i mid-DRAIN -> drain_valid_o=0 next cycle, IDLE.

Source files
------------

// File: rtl/cim_acc_buffer.sv
// Accumulation buffer for the CIM adder: read-modify-write per PE tile,
// bulk zero fill, and a sequential drain port for finished tiles.
module cim_acc_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 512
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pe_valid_i,
  input  logic [AW-1:0] pe_addr_i,
  output logic          pe_ready_o,
  output logic [DW-1:0] mem_data_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_valid_o,
  input  logic [DW-1:0] cim_result_i,
  input  logic [AW-1:0] cim_addr_i,
  input  logic          cim_valid_i,
  input  logic          clear_i,
  input  logic          drain_start_i,
  output logic [DW-1:0] drain_data_o,
  output logic [AW-1:0] drain_addr_o,
  output logic          drain_valid_o,
  input  logic          drain_ready_i,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DRAIN} state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic          clr_pend_q, clr_pend_d;
  logic          drn_pend_q, drn_pend_d;
  logic          err_q, err_d;
  logic          acc_valid_q, acc_valid_d;
  logic [AW-1:0] acc_addr_q, acc_addr_d;
  logic [DW-1:0] acc_data_q, acc_data_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          drn_valid_q, drn_valid_d;
  logic [AW-1:0] drn_addr_q, drn_addr_d;
  logic [DW-1:0] drn_data_q, drn_data_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_word;
  logic          pe_ready;
  logic          pe_fire;
  logic          cim_ok;

  assign rd_word = mem_q[rd_addr];

  always_comb begin
    state_d     = state_q;
    clr_pend_d  = clr_pend_q;
    drn_pend_d  = drn_pend_q;
    err_d       = err_q;
    clr_cnt_d   = clr_cnt_q;
    drn_valid_d = drn_valid_q;
    drn_addr_d  = drn_addr_q;
    drn_data_d  = drn_data_q;
    mem_we      = 1'b0;
    mem_waddr   = acc_addr_q;
    mem_wdata   = cim_result_i;
    rd_addr     = pe_addr_i;

    pe_ready    = (state_q == ST_IDLE) && !clr_pend_q && !drn_pend_q;
    pe_fire     = pe_valid_i && pe_ready;
    cim_ok      = acc_valid_q && cim_valid_i && (cim_addr_i == acc_addr_q);

    acc_valid_d = pe_fire;
    acc_addr_d  = pe_fire ? pe_addr_i : '0;
    acc_data_d  = '0;

    if (acc_valid_q) begin
      if (cim_ok) mem_we = 1'b1;
      else        err_d  = 1'b1;
    end
    // Forward the word being written so back-to-back tiles to one address accumulate.
    if (pe_fire) begin
      acc_data_d = (cim_ok && (acc_addr_q == pe_addr_i)) ? cim_result_i : rd_word;
    end

    case (state_q)
      ST_IDLE: begin
        if (clear_i)       clr_pend_d = 1'b1;
        if (drain_start_i) drn_pend_d = 1'b1;
        if (!acc_valid_q) begin
          if (clr_pend_q) begin
            state_d    = ST_CLEAR;
            clr_pend_d = 1'b0;
            clr_cnt_d  = '0;
          end else if (drn_pend_q) begin
            state_d     = ST_DRAIN;
            drn_pend_d  = 1'b0;
            drn_valid_d = 1'b0;
          end
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        if (clr_cnt_q == LAST) state_d   = ST_IDLE;
        else                   clr_cnt_d = clr_cnt_q + AW'(1);
      end
      ST_DRAIN: begin
        if (drn_valid_q && drain_ready_i && (drn_addr_q == LAST)) begin
          state_d     = ST_IDLE;
          drn_valid_d = 1'b0;
          drn_addr_d  = '0;
          drn_data_d  = '0;
        end else if (!drn_valid_q || drain_ready_i) begin
          rd_addr     = drn_valid_q ? (drn_addr_q + AW'(1)) : '0;
          drn_valid_d = 1'b1;
          drn_addr_d  = rd_addr;
          drn_data_d  = rd_word;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      clr_pend_q  <= 1'b0;
      drn_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_addr_q  <= '0;
      acc_data_q  <= '0;
      clr_cnt_q   <= '0;
      drn_valid_q <= 1'b0;
      drn_addr_q  <= '0;
      drn_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_pend_q  <= clr_pend_d;
      drn_pend_q  <= drn_pend_d;
      err_q       <= err_d;
      acc_valid_q <= acc_valid_d;
      acc_addr_q  <= acc_addr_d;
      acc_data_q  <= acc_data_d;
      clr_cnt_q   <= clr_cnt_d;
      drn_valid_q <= drn_valid_d;
      drn_addr_q  <= drn_addr_d;
      drn_data_q  <= drn_data_d;
    end
  end

  // Array is never reset; a reset cycle only suppresses the write in flight.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem_q[mem_waddr] <= mem_wdata;
  end

  assign pe_ready_o    = pe_ready;
  assign mem_valid_o   = acc_valid_q;
  assign mem_addr_o    = acc_addr_q;
  assign mem_data_o    = acc_data_q;
  assign drain_valid_o = drn_valid_q;
  assign drain_addr_o  = drn_addr_q;
  assign drain_data_o  = drn_data_q;
  assign busy_o        = (state_q != ST_IDLE) || clr_pend_q || drn_pend_q;
  assign err_o         = err_q;

endmodule
